// File: rtl/tetris_key_decoder_if.sv
// Command handshake bundle between the key decoder and the game logic.
// master drives cmd_valid/cmd, slave drives cmd_ready.
interface tetris_key_decoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;

  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ready
  );
endinterface

// File: rtl/tetris_key_decoder.sv
// Set-2 scancode decoder: make/break with E0/F0 prefixes, typematic filter,
// held-key bits and a FWFT command FIFO.
// Ports: clock, resetn (sync, active low), ps2_key_pressed/ps2_key_data
// (byte strobe), cmd_if (valid/ready/cmd), cmd_count, key_held, overflow.
module tetris_key_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        ps2_key_pressed,
  input  logic [7:0]                  ps2_key_data,
  tetris_key_decoder_if.master        cmd_if,
  output logic [$clog2(FIFO_DEPTH):0] cmd_count,
  output logic [5:0]                  key_held,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [5:0]      held_q, held_d;
  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [2:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            ovf_q, ovf_d;

  logic       stb;
  logic       ev_make;
  logic       ev_brk;
  logic       ev_ext;
  logic       hit;
  logic [2:0] k;
  logic       push;
  logic       pop;
  logic       full;
  logic       push_ok;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    // E1 still counts as activity for the timeout, but never moves the FSM
    stb     = ps2_key_pressed && (ps2_key_data != 8'hE1);

    if (ps2_key_pressed) begin
      tmo_d = '0;
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (stb) begin
      unique case (state_q)
        IDLE: begin
          if (ps2_key_data == 8'hE0)      state_d = EXT;
          else if (ps2_key_data == 8'hF0) state_d = BRK;
          else                            ev_make = 1'b1;
        end
        EXT: begin
          if (ps2_key_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (ps2_key_data != 8'hE0) begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hit = 1'b1;
    k   = 3'd0;
    unique case (1'b1)
      (!ev_ext && ps2_key_data == 8'h1C),
      ( ev_ext && ps2_key_data == 8'h6B): k = 3'd0;
      (!ev_ext && ps2_key_data == 8'h23),
      ( ev_ext && ps2_key_data == 8'h74): k = 3'd1;
      (!ev_ext && ps2_key_data == 8'h1D),
      ( ev_ext && ps2_key_data == 8'h75): k = 3'd2;
      (!ev_ext && ps2_key_data == 8'h1B),
      ( ev_ext && ps2_key_data == 8'h72): k = 3'd3;
      (!ev_ext && ps2_key_data == 8'h29): k = 3'd4;
      (!ev_ext && ps2_key_data == 8'h4D): k = 3'd5;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    held_d = held_q;
    push   = 1'b0;
    if (hit && ev_make && !held_q[k]) begin
      held_d[k] = 1'b1;
      push      = 1'b1;
    end
    if (hit && ev_brk) held_d[k] = 1'b0;

    pop     = (cnt_q != '0) && cmd_if.cmd_ready;
    full    = (cnt_q == CW'(FIFO_DEPTH));
    // a simultaneous pop frees the slot, so a full FIFO still accepts
    push_ok = push && (!full || pop);
    ovf_d   = ovf_q | (push && full && !pop);

    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = k;
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);

    cmd_d = cmd_q;
    if (cnt_d != '0) cmd_d = mem_d[rd_d];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      held_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  assign cmd_if.cmd_valid = (cnt_q != '0);
  assign cmd_if.cmd       = cmd_q;
  assign cmd_count        = cnt_q;
  assign key_held         = held_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Bench for tetris_key_decoder: vector table plus a command scoreboard.
// Short timeout parameter keeps the timeout cases fast.
module tb_tetris_key_decoder;

  localparam int TMO = 16;

  logic       clk;
  logic       resetn;
  logic       stb;
  logic [7:0] data;
  logic [2:0] cmd_count;
  logic [5:0] key_held;
  logic       overflow;

  tetris_key_decoder_if cif();

  tetris_key_decoder #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock           (clk),
    .resetn          (resetn),
    .ps2_key_pressed (stb),
    .ps2_key_data    (data),
    .cmd_if          (cif),
    .cmd_count       (cmd_count),
    .key_held        (key_held),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] K_STB  = 2'd0;
  localparam logic [1:0] K_IDLE = 2'd1;
  localparam logic [1:0] K_RST  = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    logic       rdy;
    int         reps;
    int         push;
    logic [5:0] held;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vq[$];
  int   sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t vs(logic [7:0] d, logic r, int p,
                              logic [5:0] h, logic [2:0] c, logic o);
    vec_t v;
    v.kind = K_STB; v.data = d; v.rdy = r; v.reps = 1;
    v.push = p; v.held = h; v.cnt = c; v.ovf = o;
    return v;
  endfunction

  function automatic vec_t vi(int n, logic r,
                              logic [5:0] h, logic [2:0] c, logic o);
    vec_t v;
    v.kind = K_IDLE; v.data = 8'h00; v.rdy = r; v.reps = n;
    v.push = -1; v.held = h; v.cnt = c; v.ovf = o;
    return v;
  endfunction

  function automatic vec_t vr();
    vec_t v;
    v.kind = K_RST; v.data = 8'h00; v.rdy = 1'b0; v.reps = 1;
    v.push = -1; v.held = '0; v.cnt = '0; v.ovf = 1'b0;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected pop happens on this edge: compare the head shown before it
  task automatic pop_check(logic r);
    if (r && sbq.size() > 0) begin
      chk("pop_valid", {31'd0, cif.cmd_valid}, 32'd1);
      chk("pop_cmd", {29'd0, cif.cmd}, sbq.pop_front());
    end
  endtask

  task automatic apply(vec_t v);
    if (v.kind == K_RST) begin
      resetn = 1'b0; stb = 1'b0; cif.cmd_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      sbq.delete();
      chk("rst_cmd", {29'd0, cif.cmd}, 32'd0);
    end else begin
      for (int i = 0; i < v.reps; i++) begin
        stb = (v.kind == K_STB);
        data = v.data;
        cif.cmd_ready = v.rdy;
        pop_check(v.rdy);
        if (v.push >= 0) sbq.push_back(v.push);
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        cif.cmd_ready = 1'b0;
      end
    end
    chk("key_held", {26'd0, key_held}, {26'd0, v.held});
    chk("cmd_count", {29'd0, cmd_count}, {29'd0, v.cnt});
    chk("overflow", {31'd0, overflow}, {31'd0, v.ovf});
    chk("cmd_valid", {31'd0, cif.cmd_valid}, {31'd0, v.cnt != 0});
    if (v.cnt != 0 && sbq.size() > 0)
      chk("head_cmd", {29'd0, cif.cmd}, sbq[0]);
  endtask

  initial begin
    resetn = 1'b0;
    stb = 1'b0;
    data = 8'h00;
    cif.cmd_ready = 1'b0;

    // make, break, pop
    vq.push_back(vr());
    vq.push_back(vs(8'h1C, 0, 0, 6'b000001, 1, 0));
    vq.push_back(vs(8'hF0, 0, -1, 6'b000001, 1, 0));
    vq.push_back(vs(8'h1C, 0, -1, 6'b000000, 1, 0));
    vq.push_back(vi(1, 1, 6'b000000, 0, 0));
    // extended make with typematic repeats, extended break
    vq.push_back(vs(8'hE0, 0, -1, 6'b000000, 0, 0));
    vq.push_back(vs(8'h74, 0, 1, 6'b000010, 1, 0));
    vq.push_back(vs(8'hE0, 0, -1, 6'b000010, 1, 0));
    vq.push_back(vs(8'h74, 0, -1, 6'b000010, 1, 0));
    vq.push_back(vs(8'hE0, 0, -1, 6'b000010, 1, 0));
    vq.push_back(vs(8'h74, 0, -1, 6'b000010, 1, 0));
    vq.push_back(vs(8'hE0, 0, -1, 6'b000010, 1, 0));
    vq.push_back(vs(8'hF0, 0, -1, 6'b000010, 1, 0));
    vq.push_back(vs(8'h74, 0, -1, 6'b000000, 1, 0));
    vq.push_back(vi(1, 1, 6'b000000, 0, 0));
    vq.push_back(vi(2, 1, 6'b000000, 0, 0));
    // fill, overflow drop, drain in order
    vq.push_back(vs(8'h1C, 0, 0, 6'b000001, 1, 0));
    vq.push_back(vs(8'h23, 0, 1, 6'b000011, 2, 0));
    vq.push_back(vs(8'h1D, 0, 2, 6'b000111, 3, 0));
    vq.push_back(vs(8'h1B, 0, 3, 6'b001111, 4, 0));
    vq.push_back(vs(8'h29, 0, -1, 6'b011111, 4, 1));
    vq.push_back(vi(1, 1, 6'b011111, 3, 1));
    vq.push_back(vi(1, 1, 6'b011111, 2, 1));
    vq.push_back(vi(2, 1, 6'b011111, 0, 1));
    // push while full with simultaneous pop is accepted
    vq.push_back(vr());
    vq.push_back(vs(8'h1C, 0, 0, 6'b000001, 1, 0));
    vq.push_back(vs(8'h23, 0, 1, 6'b000011, 2, 0));
    vq.push_back(vs(8'h1D, 0, 2, 6'b000111, 3, 0));
    vq.push_back(vs(8'h1B, 0, 3, 6'b001111, 4, 0));
    vq.push_back(vs(8'h4D, 1, 5, 6'b101111, 4, 0));
    vq.push_back(vi(3, 1, 6'b101111, 1, 0));
    vq.push_back(vi(1, 1, 6'b101111, 0, 0));
    // prefix timeout, then a short idle that must not time out
    vq.push_back(vr());
    vq.push_back(vs(8'hE0, 0, -1, 6'b000000, 0, 0));
    vq.push_back(vi(TMO + 1, 0, 6'b000000, 0, 0));
    vq.push_back(vs(8'h75, 0, -1, 6'b000000, 0, 0));
    vq.push_back(vs(8'hE0, 0, -1, 6'b000000, 0, 0));
    vq.push_back(vi(5, 0, 6'b000000, 0, 0));
    vq.push_back(vs(8'h75, 0, 2, 6'b000100, 1, 0));
    // E1 ignored inside an extended break sequence
    vq.push_back(vs(8'hE0, 0, -1, 6'b000100, 1, 0));
    vq.push_back(vs(8'hE1, 0, -1, 6'b000100, 1, 0));
    vq.push_back(vs(8'hF0, 0, -1, 6'b000100, 1, 0));
    vq.push_back(vs(8'hE1, 0, -1, 6'b000100, 1, 0));
    vq.push_back(vs(8'h75, 0, -1, 6'b000000, 1, 0));
    vq.push_back(vi(1, 1, 6'b000000, 0, 0));
    // repeated E0 stays extended
    vq.push_back(vs(8'hE0, 0, -1, 6'b000000, 0, 0));
    vq.push_back(vs(8'hE0, 0, -1, 6'b000000, 0, 0));
    vq.push_back(vs(8'h6B, 0, 0, 6'b000001, 1, 0));

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // reset in the middle of E0 F0 discards the prefix
    apply(vr());
    apply(vs(8'hE0, 0, -1, 6'b000000, 0, 0));
    apply(vs(8'hF0, 0, -1, 6'b000000, 0, 0));
    apply(vr());
    apply(vs(8'h6B, 0, -1, 6'b000000, 0, 0));
    apply(vs(8'h29, 0, 4, 6'b010000, 1, 0));
    apply(vs(8'hF0, 1, -1, 6'b010000, 0, 0));
    apply(vs(8'h29, 0, -1, 6'b000000, 0, 0));

    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_key_decoder.md
Name: tetris_key_decoder

Overview:
- Sits between the PS/2 keyboard interface and the game/VGA logic.
- Takes the raw set-2 scancode byte stream and decodes make and break sequences, including E0 and F0 prefixes.
- Suppresses typematic repeats and tracks which game keys are held.
- Queues one-shot game commands in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of command entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 2500000, idle cycles after a prefix byte before the decoder abandons the sequence (50 ms at 50 MHz).

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  synchronous active-low reset.
- ps2_key_pressed  in  1  one-cycle strobe: new byte on ps2_key_data.
- ps2_key_data  in  8  received scancode byte; sampled only when the strobe is high.
- cmd_ready  in  1  consumer accepts the head command this cycle.
- cmd_valid  out  1  FIFO non-empty; head command is presented.
- cmd  out  3  head command: 0 LEFT, 1 RIGHT, 2 ROTATE, 3 SOFT_DROP, 4 HARD_DROP, 5 PAUSE.
- cmd_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- key_held  out  6  one bit per command; 1 while the mapped key is down.
- overflow  out  1  sticky; set when a command is dropped because the FIFO is full.

Behaviour:
- Reset is synchronous: when resetn=0 at a rising edge, the next state is:
  - decoder state IDLE, timeout counter 0;
  - FIFO empty, so cmd_valid=0, cmd_count=0;
  - cmd=0, key_held=0, overflow=0.
- A reset in mid-sequence discards any partial prefix.
- Key map (suffix byte, E-flag = sequence began with E0):
  - LEFT: 1C, or E0 6B.
  - RIGHT: 23, or E0 74.
  - ROTATE: 1D, or E0 75.
  - SOFT_DROP: 1B, or E0 72.
  - HARD_DROP: 29.
  - PAUSE: 4D.
  - Any other (E-flag, byte) pair is ignored silently.
- Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Transitions on each strobe:
  - IDLE: E0 -> EXT; F0 -> BRK; otherwise a non-extended make, stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; otherwise an extended make -> IDLE.
  - BRK: any byte is a non-extended break -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
  - The byte E1 (Pause/Break key prefix) is ignored in every state; the state is unchanged.
- Timeout:
  - In EXT, BRK and EXT_BRK, the counter increments on every cycle without a strobe and clears on a strobe.
  - On reaching TIMEOUT_CYCLES, the FSM returns to IDLE.
  - A byte arriving after the timeout is decoded from IDLE.
- Make event for command k:
  - If key_held[k]=0: set key_held[k] and push k.
  - If key_held[k]=1: this is typematic; no push.
- Break event for command k: clear key_held[k]; no push.
- The two keys mapped to the same command share one held bit; a break of either key clears it.
- Latency: push happens on the edge that samples the final byte's strobe. If the FIFO was empty, cmd_valid=1 and cmd=k are visible in the following cycle.
- Pop occurs on any rising edge where cmd_valid=1 and cmd_ready=1. cmd_ready while empty has no effect.
- FIFO rules:
  - Order is strict FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd shows the head entry whenever cmd_valid=1; while empty, cmd holds its last value.
  - Push and pop in the same cycle: both occur and cmd_count is unchanged. This includes the full case, where the push is accepted.
  - Push while full with no pop: the new command is dropped, overflow is set, and FIFO contents are unchanged.
  - The held bit is still updated on a dropped push.
- overflow clears only on reset.

Test Plan:
- Reset, then bytes 1C with cmd_ready=0 -> cmd_valid=1, cmd=0, key_held=000001, cmd_count=1. Then F0 1C -> key_held=0, cmd_count stays 1.
- cmd_ready=0; send E0 74 three times (typematic) -> cmd_count=1, cmd=1, key_held[1]=1. Then E0 F0 74 -> key_held[1]=0. Raise cmd_ready for one cycle -> cmd_valid=0.
- cmd_ready=0; makes for 1C, 23, 1D, 1B, 29 -> cmd_count=4, overflow=1, key_held=011111. Holding cmd_ready=1 then pops 0, 1, 2, 3 in order, after which cmd_valid=0.
- FIFO full (4 entries), cmd_ready=1 in the same cycle as the strobe for 4D -> cmd_count stays 4, overflow=0, and the tail entry is 5.
- Send E0, wait TIMEOUT_CYCLES+1 idle cycles, then send 75 -> no command, key_held[2]=0, FSM in IDLE.
- Send E0 F0, then resetn=0 for one cycle, then send 6B -> no command; the prefix was discarded and non-extended 6B is unmapped. All outputs are at their reset values after the reset edge.
